// File: rtl/pi_out_limiter.sv
// pi_out_limiter: output stage of the PI controller.
// Clamps the raw PI output to [OUT_MIN, OUT_MAX], limits slew per accepted
// sample, soft-starts after enable and returns the anti-windup term
// (limited minus unlimited) to the PI integrator.
// Optional feature macro: SAT_FAULT_EN -- when defined, SAT_LIMIT consecutive
// saturated samples in RUN trip the FAULT state.
module pi_out_limiter #(
  parameter logic signed [31:0] OUT_MAX   = 32'sd1000,
  parameter logic signed [31:0] OUT_MIN   = -32'sd1000,
  parameter int unsigned        SLEW_STEP = 50,
  parameter int unsigned        SS_STEP   = 10,
  parameter int unsigned        SAT_LIMIT = 8
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_EN,
  input  logic               i_sample,
  input  logic signed [31:0] i_PI,
  output logic signed [31:0] o_CTRL,
  output logic signed [31:0] o_aw,
  output logic               o_valid,
  output logic               o_sat,
  output logic [1:0]         o_state,
  output logic               o_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic signed [32:0] SS_L    = 33'(SS_STEP);
  localparam logic signed [32:0] SLEW_L  = 33'(SLEW_STEP);
  localparam logic signed [31:0] SS_32   = 32'(SS_STEP);
  localparam logic signed [31:0] SLEW_32 = 32'(SLEW_STEP);

  state_t             state, state_nx;
  logic signed [31:0] ctrl, ctrl_nx;
  logic signed [31:0] aw, aw_nx;
  logic               valid, valid_nx;
  logic               sat, sat_nx;

  logic signed [31:0] clamped;
  logic               pi_sat;
  logic signed [32:0] diff;
  logic               in_ss, in_slew;
  logic signed [31:0] ramp_ctrl, run_ctrl;

`ifdef SAT_FAULT_EN
  localparam int unsigned CW = $clog2(SAT_LIMIT + 1);
  localparam logic [CW-1:0] SAT_LAST = CW'(SAT_LIMIT - 1);
  logic [CW-1:0] cnt, cnt_nx;
`else
  logic unused_sat_limit;
  assign unused_sat_limit = ^SAT_LIMIT;
`endif

  // Clamp the raw PI output and flag saturation
  always_comb begin
    if (i_PI > OUT_MAX)      clamped = OUT_MAX;
    else if (i_PI < OUT_MIN) clamped = OUT_MIN;
    else                     clamped = i_PI;
    pi_sat = (i_PI != clamped);
  end

  // Candidate commands under the soft-start and run slew limits.
  // The difference is taken at 33 bits; results stay inside the clamp range,
  // so the 32-bit add/subtract that follows cannot wrap.
  always_comb begin
    diff      = $signed({clamped[31], clamped}) - $signed({ctrl[31], ctrl});
    in_ss     = (diff <= SS_L) && (diff >= -SS_L);
    in_slew   = (diff <= SLEW_L) && (diff >= -SLEW_L);
    ramp_ctrl = in_ss ? clamped :
                ((diff > 0) ? ctrl + SS_32 : ctrl - SS_32);
    run_ctrl  = in_slew ? clamped :
                ((diff > 0) ? ctrl + SLEW_32 : ctrl - SLEW_32);
  end

  // Next-state and next-output logic; disable overrides everything but reset
  always_comb begin
    state_nx = state;
    ctrl_nx  = ctrl;
    aw_nx    = aw;
    valid_nx = 1'b0;
    sat_nx   = sat;
`ifdef SAT_FAULT_EN
    cnt_nx   = cnt;
`endif
    if (!i_EN) begin
      state_nx = IDLE;
      ctrl_nx  = '0;
      aw_nx    = '0;
`ifdef SAT_FAULT_EN
      cnt_nx   = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_nx = RAMP;
          ctrl_nx  = '0;
          aw_nx    = '0;
        end
        RAMP: begin
          if (i_sample) begin
            ctrl_nx  = ramp_ctrl;
            aw_nx    = ramp_ctrl - i_PI;
            valid_nx = 1'b1;
            sat_nx   = pi_sat;
            if (in_ss) state_nx = RUN;
          end
        end
        RUN: begin
          if (i_sample) begin
            sat_nx = pi_sat;
`ifdef SAT_FAULT_EN
            if (pi_sat && (cnt == SAT_LAST)) begin
              state_nx = FAULT;
              ctrl_nx  = '0;
              aw_nx    = '0;
              cnt_nx   = '0;
            end else begin
              ctrl_nx  = run_ctrl;
              aw_nx    = run_ctrl - i_PI;
              valid_nx = 1'b1;
              cnt_nx   = pi_sat ? cnt + 1'b1 : '0;
            end
`else
            ctrl_nx  = run_ctrl;
            aw_nx    = run_ctrl - i_PI;
            valid_nx = 1'b1;
`endif
          end
        end
        FAULT: begin
          ctrl_nx = '0;
          aw_nx   = '0;
        end
        default: begin
          state_nx = IDLE;
          ctrl_nx  = '0;
          aw_nx    = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= IDLE;
      ctrl  <= '0;
      aw    <= '0;
      valid <= 1'b0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      ctrl  <= ctrl_nx;
      aw    <= aw_nx;
      valid <= valid_nx;
      sat   <= sat_nx;
    end
  end

`ifdef SAT_FAULT_EN
  // Consecutive-saturation counter
  always_ff @(posedge i_CLK) begin
    if (i_RST) cnt <= '0;
    else       cnt <= cnt_nx;
  end

  assign o_fault = (state == FAULT);
`else
  assign o_fault = 1'b0;
`endif

  assign o_CTRL  = ctrl;
  assign o_aw    = aw;
  assign o_valid = valid;
  assign o_sat   = sat;
  assign o_state = state;

endmodule

// File: tb/tb_pi_out_limiter.sv
// Testbench for pi_out_limiter: directed test-plan sequences followed by
// random stimulus, checked through a scoreboard fed by a reference model.
module tb_pi_out_limiter;

  localparam int OMAX = 1000;
  localparam int OMIN = -1000;
  localparam int SLEW = 50;
  localparam int SS   = 10;
  localparam int SATN = 8;
`ifdef SAT_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               smp = 1'b0;
  logic signed [31:0] pi = '0;
  logic signed [31:0] ctrl_o, aw_o;
  logic               valid_o, sat_o, fault_o;
  logic [1:0]         state_o;

  pi_out_limiter #(
    .OUT_MAX  (32'sd1000),
    .OUT_MIN  (-32'sd1000),
    .SLEW_STEP(50),
    .SS_STEP  (10),
    .SAT_LIMIT(8)
  ) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_EN    (en),
    .i_sample(smp),
    .i_PI    (pi),
    .o_CTRL  (ctrl_o),
    .o_aw    (aw_o),
    .o_valid (valid_o),
    .o_sat   (sat_o),
    .o_state (state_o),
    .o_fault (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ctrl;
    int aw;
    bit valid;
    bit sat;
    bit fault;
  } status_t;

  typedef struct {
    int ctrl;
    int aw;
    bit sat;
  } txn_t;

  status_t sq[$];
  txn_t    tq[$];
  int      n_checks = 0;
  int      n_fail = 0;

  // Reference model state (0 IDLE, 1 RAMP, 2 RUN, 3 FAULT)
  int m_st = 0, m_ctrl = 0, m_aw = 0, m_cnt = 0;
  bit m_sat = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    status_t s;
    txn_t    t;
    int      c, d, lim, nc;
    bit      v = 1'b0;
    if (rst) begin
      m_st = 0; m_ctrl = 0; m_aw = 0; m_sat = 0; m_cnt = 0;
    end else if (!en) begin
      m_st = 0; m_ctrl = 0; m_aw = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if ((m_st == 1 || m_st == 2) && smp) begin
      c = (pi > OMAX) ? OMAX : ((pi < OMIN) ? OMIN : int'(pi));
      m_sat = (c != pi);
      if (m_st == 2 && FEN && m_sat && (m_cnt + 1 == SATN)) begin
        m_st = 3; m_ctrl = 0; m_aw = 0; m_cnt = 0;
      end else begin
        lim = (m_st == 1) ? SS : SLEW;
        d = c - m_ctrl;
        if (d <= lim && d >= -lim) nc = c;
        else nc = (d > 0) ? m_ctrl + lim : m_ctrl - lim;
        m_ctrl = nc;
        m_aw = nc - int'(pi);
        v = 1'b1;
        if (m_st == 2) m_cnt = m_sat ? m_cnt + 1 : 0;
        if (m_st == 1 && d <= lim && d >= -lim) m_st = 2;
      end
    end
    s.st = m_st; s.ctrl = m_ctrl; s.aw = m_aw;
    s.valid = v; s.sat = m_sat; s.fault = (m_st == 3);
    sq.push_back(s);
    if (v) begin
      t.ctrl = m_ctrl; t.aw = m_aw; t.sat = m_sat;
      tq.push_back(t);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit s, input int p);
    @(negedge clk);
    rst = r; en = e; smp = s; pi = p;
    model_edge();
  endtask

  // k samples at value p, one every n cycles
  task automatic samples(input int k, input int n, input int p);
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 1'b1, 1'b1, p);
      for (int j = 1; j < n; j++) drive(1'b0, 1'b1, 1'b0, p);
    end
  endtask

  // Monitor: per-cycle status check plus transaction check on o_valid
  always @(posedge clk) begin
    status_t s;
    txn_t    t;
    #1;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("state", state_o, s.st);
      chk("ctrl", ctrl_o, s.ctrl);
      chk("aw", aw_o, s.aw);
      chk("valid", valid_o, s.valid);
      chk("sat", sat_o, s.sat);
      chk("fault", fault_o, s.fault);
    end
    if (valid_o) begin
      if (tq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        t = tq.pop_front();
        chk("txn_ctrl", ctrl_o, t.ctrl);
        chk("txn_aw", aw_o, t.aw);
        chk("txn_sat", sat_o, t.sat);
      end
    end
  end

  initial begin
    int p, r;
    // Reset with arbitrary inputs
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), int'($urandom));
    drive(1'b0, 1'b0, 1'b0, 0);
    // Soft start to 100
    drive(1'b0, 1'b1, 1'b0, 100);
    samples(10, 4, 100);
    // Slew to 400, then up to the limit
    samples(6, 2, 400);
    samples(12, 2, 1000);
    // Sustained saturation
    samples(10, 2, 2000);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    // Ramp to 300 then disable/sample collision
    drive(1'b0, 1'b1, 1'b0, 300);
    samples(30, 1, 300);
    drive(1'b0, 1'b0, 1'b1, 300);
    drive(1'b0, 1'b0, 1'b0, 300);
    // Reset mid-ramp at 40, then ramp restarts from 0
    drive(1'b0, 1'b1, 1'b0, 100);
    samples(4, 2, 100);
    drive(1'b1, 1'b1, 1'b1, 100);
    drive(1'b0, 1'b1, 1'b0, 100);
    samples(3, 2, 100);
    // Negative saturation and downward slew
    samples(20, 1, -1500);
    samples(5, 1, 0);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) p = (($urandom & 1) != 0) ? int'($urandom_range(1001, 2500))
                                         : -int'($urandom_range(1001, 2500));
      else       p = int'($urandom_range(0, 2400)) - 1200;
      drive(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) != 0),
            ($urandom_range(0, 2) == 0), p);
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("pending_txn", tq.size(), 0);
    chk("pending_status", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
